// File: rtl/motif_pkg.sv
// ============================================================================
// Module      : motif_pkg
// Description : Motif codes shared with motif_classifier, and scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package motif_pkg;

    localparam logic [3:0] MOTIF_STATIC   = 4'h0;
    localparam logic [3:0] MOTIF_RESERVED = 4'hF;
    localparam logic [3:0] MOTIF_ERR      = MOTIF_RESERVED;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_ISSUE = C_ST_ISSUE,
        ST_WAIT  = C_ST_WAIT,
        ST_RESP  = C_ST_RESP
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/motif_sched_if.sv
// ============================================================================
// Module      : motif_sched_if
// Description : Request, classifier and response channels of motif_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motif_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [64*NUM_REQ-1:0] req_delta;
    logic [NUM_REQ-1:0]    req_ready;
    logic [63:0]           cls_delta;
    logic                  cls_delta_valid;
    logic [3:0]            cls_motif_id;
    logic                  cls_motif_valid;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [3:0]            rsp_motif;
    logic                  rsp_err;
    logic                  busy;
    logic [7:0]            err_count;

    // master is the scheduler; slave is the requester/classifier/consumer side
    modport master (
        input  req_valid, req_delta, cls_motif_id, cls_motif_valid, rsp_ready,
        output req_ready, cls_delta, cls_delta_valid, rsp_valid, rsp_id,
               rsp_motif, rsp_err, busy, err_count
    );

    modport slave (
        output req_valid, req_delta, cls_motif_id, cls_motif_valid, rsp_ready,
        input  req_ready, cls_delta, cls_delta_valid, rsp_valid, rsp_id,
               rsp_motif, rsp_err, busy, err_count
    );
endinterface

`default_nettype wire

// File: rtl/motif_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter, searching up from last_grant+1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    int w_pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_pos     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(last_grant) + k) % NUM_REQ;
            if (!any_grant && req[ID_W'(w_pos)]) begin
                grant[ID_W'(w_pos)] = 1'b1;
                grant_idx           = ID_W'(w_pos);
                any_grant           = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/motif_sched.sv
// ============================================================================
// Module      : motif_sched
// Description : Round-robin sharing of one motif_classifier with timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motif_sched
    import motif_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    motif_sched_if.master bus
);

    sched_state_t       r_state;
    logic [ID_W-1:0]    r_last_grant;
    logic [7:0]         r_cnt;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    logic [63:0]        w_sel_delta;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any_grant  (w_any)
    );

    assign w_sel_delta   = bus.req_delta[int'(w_grant_idx)*64 +: 64];
    assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign bus.busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= ST_IDLE;
            r_last_grant        <= ID_W'(NUM_REQ - 1);
            r_cnt               <= '0;
            bus.cls_delta       <= '0;
            bus.cls_delta_valid <= 1'b0;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_id          <= '0;
            bus.rsp_motif       <= MOTIF_STATIC;
            bus.rsp_err         <= 1'b0;
            bus.err_count       <= '0;
        end else begin
            bus.cls_delta_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A grant is only ever given to a valid requester, so any grant is a handshake
                    if (w_any) begin
                        bus.cls_delta       <= w_sel_delta;
                        bus.cls_delta_valid <= 1'b1;
                        bus.rsp_id          <= w_grant_idx;
                        r_last_grant        <= w_grant_idx;
                        r_state             <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.cls_motif_valid) begin
                        bus.rsp_motif <= bus.cls_motif_id;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (r_cnt == 8'(TIMEOUT)) begin
                        bus.rsp_motif <= MOTIF_ERR;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        if (bus.err_count != 8'hFF) begin
                            bus.err_count <= bus.err_count + 8'd1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_motif_sched.sv
// ============================================================================
// Module      : tb_motif_sched
// Description : Directed self-checking bench for motif_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motif_sched;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [63:0] exp_delta [4];

    motif_sched_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    motif_sched #(
        .NUM_REQ (4),
        .ID_W    (2),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the accept cycle T with req_valid already driven
    task automatic run_txn(input int id, input logic [3:0] motif);
        logic [3:0] oh;
        oh = 4'(1 << id);
        #1 check("grant", 64'(bus.req_ready), 64'(oh));
        @(negedge clk);
        #1 check("issue_pulse", 64'(bus.cls_delta_valid), 64'd1);
        check("issue_delta", bus.cls_delta, exp_delta[id]);
        check("issue_ready_low", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.cls_motif_valid = 1'b1;
        bus.cls_motif_id    = motif;
        #1 check("pulse_one_cycle", 64'(bus.cls_delta_valid), 64'd0);
        @(negedge clk);
        bus.cls_motif_valid = 1'b0;
        bus.cls_motif_id    = 4'h0;
        #1 check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_id", 64'(bus.rsp_id), 64'(id));
        check("rsp_motif", 64'(bus.rsp_motif), 64'(motif));
        check("rsp_err", 64'(bus.rsp_err), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_cls_delta"}, bus.cls_delta, 64'd0);
        check({tag, "_cls_valid"}, 64'(bus.cls_delta_valid), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        check({tag, "_rsp_motif"}, 64'(bus.rsp_motif), 64'd0);
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_delta[0] = 64'h0123_4567_89AB_CDEF;
        exp_delta[1] = 64'hFEDC_BA98_7654_3210;
        exp_delta[2] = 64'h0000_0000_0000_0000;
        exp_delta[3] = 64'hA5A5_5A5A_DEAD_BEEF;

        rst_n               = 1'b0;
        bus.req_valid       = 4'b0000;
        bus.req_delta       = {exp_delta[3], exp_delta[2], exp_delta[1], exp_delta[0]};
        bus.cls_motif_valid = 1'b0;
        bus.cls_motif_id    = 4'h0;
        bus.rsp_ready       = 1'b1;

        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single all-zero request from requester 2
        @(negedge clk);
        bus.req_valid = 4'b0100;
        run_txn(2, 4'h0);
        bus.req_valid = 4'b0000;
        #1 check("single_back_idle", 64'(bus.busy), 64'd0);

        // Fresh reset so requester 0 leads, then all four contend
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'b1111;
        run_txn(0, 4'h3);
        run_txn(1, 4'h5);
        run_txn(2, 4'h0);
        run_txn(3, 4'h9);
        run_txn(0, 4'h3);

        // Backpressure: response held for ten cycles
        bus.rsp_ready = 1'b0;
        run_txn(1, 4'h6);
        for (int k = 0; k < 9; k++) begin
            #1 check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
            check("bp_rsp_motif", 64'(bus.rsp_motif), 64'h6);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            if (k == 8) bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        #1 check("bp_resume_grant", 64'(bus.req_ready), 64'b0100);
        bus.req_valid = 4'b0000;

        // Spurious classifier result while idle
        @(negedge clk);
        bus.cls_motif_valid = 1'b1;
        bus.cls_motif_id    = 4'h5;
        @(negedge clk);
        bus.cls_motif_valid = 1'b0;
        bus.cls_motif_id    = 4'h0;
        #1 check("spur_busy", 64'(bus.busy), 64'd0);
        check("spur_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        #1 check("spur_rsp_valid2", 64'(bus.rsp_valid), 64'd0);
        check("spur_rsp_motif", 64'(bus.rsp_motif), 64'h6);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        run_txn(2, 4'h9);

        // Timeout with a silent classifier
        bus.req_valid = 4'b0001;
        #1 check("to_grant", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1 check("to_issue", 64'(bus.cls_delta_valid), 64'd1);
        repeat (9) @(negedge clk);
        #1 check("to_not_yet", 64'(bus.rsp_valid), 64'd0);
        check("to_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        #1 check("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("to_rsp_motif", 64'(bus.rsp_motif), 64'hF);
        check("to_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("to_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("to_err_count", 64'(bus.err_count), 64'd1);
        @(negedge clk);
        #1 check("to_back_idle", 64'(bus.busy), 64'd0);

        // Many more timeouts saturate the counter
        bus.req_valid = 4'b0001;
        repeat (300 * 12) @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (20) @(negedge clk);
        #1 check("sat_err_count", 64'(bus.err_count), 64'd255);
        check("sat_idle", 64'(bus.busy), 64'd0);

        // Reset while waiting on the classifier
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1 check("mr_grant", 64'(bus.req_ready), 64'b1000);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n               = 1'b0;
        bus.cls_motif_valid = 1'b1;
        bus.cls_motif_id    = 4'h7;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #1 check("mr_no_rsp", 64'(bus.rsp_valid), 64'd0);
        rst_n               = 1'b1;
        bus.cls_motif_valid = 1'b0;
        bus.cls_motif_id    = 4'h0;
        bus.req_valid       = 4'b1111;
        run_txn(0, 4'h2);
        bus.req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/motif_sched.md
# motif_sched

Round-robin scheduler that shares the single `motif_classifier` instance among `NUM_REQ` delta producers. It accepts one delta at a time from a requester and drives it into the classifier as a one-cycle `delta_valid` pulse. It captures the classifier result and returns it on a tagged valid/ready response channel. A watchdog returns an error code (`4'hF`) if the classifier fails to respond, so one lost result cannot hang the pipeline.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester tag width, equal to clog2(`NUM_REQ`).
- `TIMEOUT`, 8: maximum WAIT cycles before an error response (1..255).

Ports:
- `clk`  in  1  system clock (27 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester delta valid.
- `req_delta`  in  64*`NUM_REQ`  requester i occupies bits [i*64 +: 64].
- `req_ready`  out  `NUM_REQ`  one-hot grant; requester i's delta is accepted when `req_valid[i]` and `req_ready[i]` are both high.
- `cls_delta`  out  64  delta to the classifier.
- `cls_delta_valid`  out  1  one-cycle issue pulse.
- `cls_motif_id`  in  4  classifier result.
- `cls_motif_valid`  in  1  classifier result valid.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  `ID_W`  index of the requester the response belongs to.
- `rsp_motif`  out  4  motif code, or `4'hF` on timeout.
- `rsp_err`  out  1  high when the response came from a timeout.
- `busy`  out  1  high in any state other than IDLE.
- `err_count`  out  8  saturating count of timeouts.

## Operation
State machine IDLE, ISSUE, WAIT, RESP:
- **IDLE**
  - Arbiter selects the first requester with `req_valid` high, searching upward from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready` is high only for that requester, and is driven combinationally from `req_valid`.
  - On the handshake: latch the delta into `cls_delta`, latch the index into `rsp_id`, set `last_grant` to that index, go to ISSUE.
  - If no `req_valid` is high, `req_ready` is all zero.
- **ISSUE**: `cls_delta_valid` = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- **WAIT**
  - If `cls_motif_valid` is high: capture `cls_motif_id` into `rsp_motif`, set `rsp_err`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: `rsp_motif`=`4'hF`, `rsp_err`=1, increment `err_count` (it saturates at 255), go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_motif` and `rsp_err` stay stable until `rsp_ready` is high.
  - Return to IDLE on the cycle `rsp_ready` is high.
- `req_ready` is zero in every state except IDLE.
- `cls_motif_valid` outside WAIT is ignored and discarded.
- `cls_delta` holds its last value between issues.
- An all-zero delta is legal and is forwarded unchanged. The classifier answers it with `4'h0`.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=0, `cls_delta`=0, `cls_delta_valid`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_motif`=0, `rsp_err`=0.
  - `busy`=0, `err_count`=0.
  - `last_grant`=`NUM_REQ`-1, so requester 0 has first priority.
- All outputs are registered except `req_ready` and `busy`, which are decoded from the state.
- Nominal latency:
  - Handshake in cycle T.
  - `cls_delta_valid` high in T+1.
  - Classifier responds in T+2.
  - `rsp_valid` high in T+3.
  - With `rsp_ready` held high, the next accept happens in T+4. Peak throughput is 1 delta per 4 cycles.
- Timeout response: `rsp_valid` rises `TIMEOUT`+2 cycles after ISSUE.
- Reset asserted mid-transaction: the transaction is abandoned with no response, and all outputs go to their reset values immediately, asynchronously.
- A requester dropping `req_valid` without a handshake is legal. The arbiter re-evaluates every IDLE cycle.

## Structure
- Shared package `motif_pkg`:
  - Motif code constants `MOTIF_STATIC` (0) through `MOTIF_RESERVED` (`4'hF`), also used by `motif_classifier`.
  - `MOTIF_ERR` = `MOTIF_RESERVED`.
  - State encoding localparams for this block.
- One sub-module, `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational.

## Test plan
- **Reset then single request.** Apply reset; requester 2 presents `req_delta=64'h0`. Expect:
  - `cls_delta_valid` in T+1.
  - `rsp_valid` in T+3 with `rsp_id`=2, `rsp_motif`=0, `rsp_err`=0.
- **Fairness.** All 4 requesters valid continuously. Expect grant order 0,1,2,3,0, with accepts exactly 4 cycles apart.
- **Response backpressure.** Hold `rsp_ready`=0 for 10 cycles. Expect:
  - `rsp_valid` and the payload stable throughout.
  - `req_ready` all zero throughout.
  - Accept resumes the cycle after `rsp_ready` returns high.
- **Timeout.** Stub classifier never asserts valid. Expect:
  - `rsp_motif`=`4'hF` and `rsp_err`=1 at ISSUE+10 with `TIMEOUT`=8.
  - `err_count` increments to 1.
  - 300 timeouts leave `err_count` at 255.
- **Spurious result.** Pulse `cls_motif_valid` while in IDLE. Expect no response and no state change.
- **Mid-flight reset.** Assert `rst_n`=0 during WAIT. Expect all outputs at reset values with no response emitted. After release, requester 0 wins first.
